// File: rtl/stream_mux_rr_if.sv
// Valid/ready bus bundle for stream_mux_rr: N producer channels in, one consumer out.
// master = producers/consumer side, slave = the multiplexer.
interface stream_mux_rr_if #(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_inputs = 4,
    parameter int unsigned sel_width  = 2
);
    logic                             mode;
    logic [sel_width-1:0]             sel;
    logic [num_inputs*data_width-1:0] in_data;
    logic [num_inputs-1:0]            in_valid;
    logic [num_inputs-1:0]            in_last;
    logic [num_inputs-1:0]            in_ready;
    logic [data_width-1:0]            out_data;
    logic                             out_valid;
    logic [sel_width-1:0]             out_src;
    logic                             out_ready;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with registered output and round-robin or fixed-select arbitration.
// Optional packet lock (no interleaving until in_last) is enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_inputs = 4,
    parameter int unsigned sel_width  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int unsigned last_ch = num_inputs - 1;

    logic [sel_width-1:0]  ptr;
    logic [sel_width-1:0]  ptr_next;
    logic [num_inputs-1:0] grant;
    logic [sel_width-1:0]  grant_idx;
    logic                  grant_any;
    logic [data_width-1:0] grant_data;
    logic                  load;
    logic                  xfer;
    logic                  locked;
    logic [sel_width-1:0]  lock_ch;

    logic                  beat_valid;
    logic [data_width-1:0] beat_data;
    logic [sel_width-1:0]  beat_src;

`ifdef STREAM_MUX_LOCK_EN
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t          lock_state;
    lock_state_t          lock_state_next;
    logic [sel_width-1:0] lock_ch_next;
    logic                 xfer_last;

    assign xfer_last = |(grant & bus.in_last);
    assign locked    = (lock_state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state <= UNLOCKED;
            lock_ch    <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_ch    <= lock_ch_next;
        end
    end

    // A non-final beat pins the granted channel until its final beat goes through.
    always_comb begin
        lock_state_next = lock_state;
        lock_ch_next    = lock_ch;
        case (lock_state)
            UNLOCKED: begin
                if (xfer && !xfer_last) begin
                    lock_state_next = LOCKED;
                    lock_ch_next    = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && xfer_last) lock_state_next = UNLOCKED;
            end
            default: lock_state_next = UNLOCKED;
        endcase
    end
`else
    logic unused_last;

    assign unused_last = ^bus.in_last;
    assign locked      = 1'b0;
    assign lock_ch     = '0;
`endif

    // Grant selection: lock overrides everything, then fixed select, then round-robin from ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (locked) begin
            grant_any = 1'b1;
            grant_idx = lock_ch;
        end else if (bus.mode) begin
            if (int'(bus.sel) < int'(num_inputs)) begin
                grant_any = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            for (int k = 0; k < int'(num_inputs); k++) begin
                if (!grant_any && bus.in_valid[k] && (k >= int'(ptr))) begin
                    grant_any = 1'b1;
                    grant_idx = sel_width'(k);
                end
            end
            for (int k = 0; k < int'(num_inputs); k++) begin
                if (!grant_any && bus.in_valid[k] && (k < int'(ptr))) begin
                    grant_any = 1'b1;
                    grant_idx = sel_width'(k);
                end
            end
        end
    end

    always_comb begin
        grant      = '0;
        grant_data = '0;
        for (int k = 0; k < int'(num_inputs); k++) begin
            if (grant_any && (int'(grant_idx) == k)) begin
                grant[k]   = 1'b1;
                grant_data = bus.in_data[k*data_width +: data_width];
            end
        end
    end

    assign load         = !beat_valid || bus.out_ready;
    assign bus.in_ready = grant & {num_inputs{load & rst_n}};
    assign xfer         = |(bus.in_valid & bus.in_ready);

    // Pointer moves past the served channel; fixed-select beats outside a packet leave it alone.
    always_comb begin
        ptr_next = ptr;
        if (xfer && (!bus.mode || locked)) begin
            ptr_next = (int'(grant_idx) == int'(last_ch)) ? '0 : grant_idx + sel_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_next;
    end

    // Output stage: a new beat replaces the held one; a drain with no refill clears valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_valid <= 1'b0;
            beat_data  <= '0;
            beat_src   <= '0;
        end else if (xfer) begin
            beat_valid <= 1'b1;
            beat_data  <= grant_data;
            beat_src   <= grant_idx;
        end else if (bus.out_ready) begin
            beat_valid <= 1'b0;
        end
    end

    assign bus.out_valid = beat_valid;
    assign bus.out_data  = beat_data;
    assign bus.out_src   = beat_src;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: behavioural model compared every cycle plus directed literals.
module tb_stream_mux_rr;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   check_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.data_width(DW), .num_inputs(N), .sel_width(SW)) b4 ();
    stream_mux_rr_if #(.data_width(DW), .num_inputs(3), .sel_width(SW)) b3 ();

    stream_mux_rr #(.data_width(DW), .num_inputs(N), .sel_width(SW)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );
    stream_mux_rr #(.data_width(DW), .num_inputs(3), .sel_width(SW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [3:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    // Which channel the rules say is granted this cycle, or -1.
    function automatic int exp_grant(input int p, input logic lk, input int lc,
                                     input logic md, input int s, input logic [3:0] v);
        if (lk) return lc;
        if (md) return (s < int'(N)) ? s : -1;
        for (int i = 0; i < int'(N); i++) begin
            int c;
            c = (p + i) % int'(N);
            if (bit_of(v, c)) return c;
        end
        return -1;
    endfunction

    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_src = 0;
    logic        m_locked = 1'b0;
    int          m_lc = 0;

    always @(posedge clk) begin
        int   g;
        logic ld;
        g  = exp_grant(m_ptr, m_locked, m_lc, b4.mode, int'(b4.sel), b4.in_valid);
        ld = !m_valid || b4.out_ready;
        if (!rst_n) begin
            m_ptr <= 0; m_valid <= 1'b0; m_data <= '0; m_src <= 0; m_locked <= 1'b0; m_lc <= 0;
        end else if (g >= 0 && ld && bit_of(b4.in_valid, g)) begin
            m_valid <= 1'b1;
            m_data  <= DW'(b4.in_data >> (g * int'(DW)));
            m_src   <= g;
            if (!b4.mode || m_locked) m_ptr <= (g + 1) % int'(N);
`ifdef STREAM_MUX_LOCK_EN
            if (!m_locked && !bit_of(b4.in_last, g)) begin
                m_locked <= 1'b1;
                m_lc     <= g;
            end else if (m_locked && bit_of(b4.in_last, g)) begin
                m_locked <= 1'b0;
            end
`endif
        end else if (b4.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int         g;
        logic [3:0] er;
        if (check_en) begin
            g  = exp_grant(m_ptr, m_locked, m_lc, b4.mode, int'(b4.sel), b4.in_valid);
            er = (rst_n && (!m_valid || b4.out_ready) && g >= 0) ? (4'd1 << g) : 4'd0;
            chk("in_ready",  64'(b4.in_ready),  64'(er));
            chk("out_valid", 64'(b4.out_valid), 64'(m_valid));
            chk("out_data",  64'(b4.out_data),  64'(m_data));
            chk("out_src",   64'(b4.out_src),   64'(m_src));
        end
    end

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < int'(N); k++) b4.in_data[k*DW +: DW] = $urandom;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_src(input string nm, input int e);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(b4.out_valid), 64'(1));
        chk(nm, 64'(b4.out_src), 64'(e));
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b0;
        step();
        step(); rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lock[4];
        int got[$];
        int cnt;
        logic fire;

        b4.mode = 1'b0; b4.sel = '0; b4.in_valid = '1; b4.in_last = '1; b4.out_ready = 1'b1;
        b3.mode = 1'b1; b3.sel = 2'd3; b3.in_valid = '1; b3.in_last = '1; b3.out_ready = 1'b1;
        b3.in_data = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        rst_n = 1'b0;

        // Reset with all channels valid, then round-robin over all four.
        step(); check_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(b4.in_ready),  64'(0));
        chk("rst_out_valid", 64'(b4.out_valid), 64'(0));
        chk("rst_out_data",  64'(b4.out_data),  64'(0));
        step(); rst_n = 1'b1;
        @(posedge clk);
        check_src("rr0", 0); check_src("rr1", 1); check_src("rr2", 2);
        check_src("rr3", 3); check_src("rr4", 0); check_src("rr5", 1);

        // Sparse channels 1 and 3 starting from ptr=2.
        step(); b4.in_valid = 4'b0000;
        step(); b4.in_valid = 4'b0010;
        step(); b4.in_valid = 4'b1010;
        check_src("sp_seed", 1);
        check_src("sp0", 3); check_src("sp1", 1); check_src("sp2", 3); check_src("sp3", 1);

        // Backpressure: one beat held for several cycles, then back-to-back drain.
        do_reset();
        b4.in_valid = 4'b1111; b4.out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) check_src("bp_hold", 0);
        step(); b4.out_ready = 1'b1;
        check_src("bp_last_held", 0);
        check_src("bp0", 1); check_src("bp1", 2); check_src("bp2", 3); check_src("bp3", 0);

        // Fixed select on both instances; sel=3 with three channels grants nothing.
        step(); b4.mode = 1'b1; b4.sel = 2'd2;
        chk("n3_sel3_ready", 64'(b3.in_ready),  64'(0));
        chk("n3_sel3_valid", 64'(b3.out_valid), 64'(0));
        b3.sel = 2'd2;
        @(negedge clk);
        chk("n3_sel2_ready", 64'(b3.in_ready), 64'(3'b100));
        check_src("fx0", 2);
        chk("n3_sel2_valid", 64'(b3.out_valid), 64'(1));
        chk("n3_sel2_src",   64'(b3.out_src),   64'(2));
        chk("n3_sel2_data",  64'(b3.out_data),  64'(32'h3333_0002));
        check_src("fx1", 2); check_src("fx2", 2);
        step(); b4.mode = 1'b0;

        // Three-beat packet on channel 1 competing with channel 2.
        do_reset();
        b4.in_valid = 4'b0110; b4.in_last = 4'b1101;
`ifdef STREAM_MUX_LOCK_EN
        exp_lock = '{1, 1, 1, 2};
`else
        exp_lock = '{1, 2, 1, 2};
`endif
        cnt = 0;
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            @(negedge clk);
            if (b4.out_valid) got.push_back(int'(b4.out_src));
            fire = b4.in_valid[1] && b4.in_ready[1];
            step();
            if (fire) cnt++;
            b4.in_valid[1] = (cnt < 3);
            b4.in_last[1]  = (cnt == 2);
        end
        chk("lock_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) chk("lock_seq", 64'(got[i]), 64'(exp_lock[i]));

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            step();
            b4.in_valid  = 4'($urandom);
            b4.in_last   = 4'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
            b4.mode      = ($urandom_range(0, 7) == 0);
            b4.sel       = 2'($urandom);
            rst_n        = ($urandom_range(0, 99) != 0);
        end
        step(); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
